// File: rtl/csr_excp_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_excp_unit_pkg
// Description : Shared CSR addresses, field layouts, write-port record and the
//               redirect FSM state type for the exception CSR unit.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_excp_unit_pkg;

    localparam logic [13:0] c_ADDR_CRMD      = 14'h0;
    localparam logic [13:0] c_ADDR_PRMD      = 14'h1;
    localparam logic [13:0] c_ADDR_ECFG      = 14'h4;
    localparam logic [13:0] c_ADDR_ESTAT     = 14'h5;
    localparam logic [13:0] c_ADDR_ERA       = 14'h6;
    localparam logic [13:0] c_ADDR_BADV      = 14'h7;
    localparam logic [13:0] c_ADDR_EENTRY    = 14'hC;
    localparam logic [13:0] c_ADDR_TLBEHI    = 14'h11;
    localparam logic [13:0] c_ADDR_TLBRENTRY = 14'h88;

    localparam logic [5:0]  c_ECODE_TLBR     = 6'h3F;

    // Software-writable bits of each CSR; everything outside a mask is read-only.
    localparam logic [31:0] c_CRMD_WMASK     = 32'h0000_01ff;  // PLV,IE,DA,PG,DATF,DATM
    localparam logic [31:0] c_PRMD_WMASK     = 32'h0000_0007;  // PPLV,PIE
    localparam logic [31:0] c_ECFG_WMASK     = 32'h0007_1bff;  // LIE (bit 10 reserved), VS
    localparam logic [31:0] c_ESTAT_WMASK    = 32'h0000_0003;  // software interrupt IS[1:0]
    localparam logic [31:0] c_ENTRY_WMASK    = 32'hffff_ffc0;  // EENTRY/TLBRENTRY, 64B aligned
    localparam logic [31:0] c_TLBEHI_WMASK   = 32'hffff_e000;  // VPPN

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [31:0] data;
    } csr_write_signal;

    typedef struct packed {
        logic [22:0] rsvd;
        logic [1:0]  datm;
        logic [1:0]  datf;
        logic        pg;
        logic        da;
        logic        ie;
        logic [1:0]  plv;
    } crmd_t;

    typedef struct packed {
        logic        rsvd31;
        logic [8:0]  esubcode;
        logic [5:0]  ecode;
        logic [2:0]  rsvd15_13;
        logic [12:0] is;
    } estat_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } redir_state_t;

    // Replace only the masked bits of a CSR with write data.
    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [31:0] mask);
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_excp_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_excp_unit_if
// Description : Commit-stage to CSR unit bundle: committed CSR writes and the
//               exception / ERTN event with its payload.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_excp_unit_if;
    import csr_excp_unit_pkg::*;

    csr_write_signal csr_w_i_0;
    csr_write_signal csr_w_i_1;
    logic            excp_i;
    logic            ertn_i;
    logic [31:0]     csr_era_i;
    logic [5:0]      csr_ecode_i;
    logic [8:0]      csr_esubcode_i;
    logic            va_error_i;
    logic [31:0]     bad_va_i;
    logic            excp_tlbrefill_i;
    logic            excp_tlb_i;
    logic [18:0]     excp_tlb_vppn_i;

    modport master (
        output csr_w_i_0, csr_w_i_1, excp_i, ertn_i, csr_era_i, csr_ecode_i,
               csr_esubcode_i, va_error_i, bad_va_i, excp_tlbrefill_i,
               excp_tlb_i, excp_tlb_vppn_i
    );

    modport slave (
        input  csr_w_i_0, csr_w_i_1, excp_i, ertn_i, csr_era_i, csr_ecode_i,
               csr_esubcode_i, va_error_i, bad_va_i, excp_tlbrefill_i,
               excp_tlb_i, excp_tlb_vppn_i
    );
endinterface
`default_nettype wire

// File: rtl/csr_excp_unit_redirect_fsm.sv
`default_nettype none
// ============================================================================
// Module      : csr_redirect_fsm
// Description : Holds a redirect target for fetch until it is accepted through
//               a valid/ready handshake. New requests are only taken in IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_redirect_fsm
    import csr_excp_unit_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_start,
    input  wire logic [31:0] i_target,
    input  wire logic        i_ready,
    output logic             o_valid,
    output logic [31:0]      o_pc,
    output logic             o_idle
);

    redir_state_t r_state;
    redir_state_t w_state_nx;
    logic [31:0]  r_pc;

    // State register; async reset drops a pending redirect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nx = r_state;
        o_valid    = 1'b0;
        o_idle     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_idle = 1'b1;
                if (i_start) w_state_nx = ST_REDIR;
            end
            ST_REDIR: begin
                o_valid = 1'b1;
                if (i_ready) w_state_nx = ST_REDIR == ST_REDIR ? ST_IDLE : ST_REDIR;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Target latch; stays stable for the whole time valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_pc <= 32'h0;
        else if (r_state == ST_IDLE && i_start) r_pc <= i_target;
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/csr_excp_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_excp_unit
// Description : Exception CSR file. Applies committed CSR writes, exception
//               entry and ERTN return, raises interrupt requests and drives
//               the fetch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_excp_unit
    import csr_excp_unit_pkg::*;
#(
    parameter logic [31:0] RESET_EENTRY = 32'h1c00_0000,
    parameter int          HWI_W        = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    csr_excp_unit_if.slave        cmt,
    input  wire logic [HWI_W-1:0] hw_int_i,
    input  wire logic [13:0]      csr_raddr_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  redirect_valid_o,
    output logic [31:0]           redirect_pc_o,
    input  wire logic             redirect_ready_i,
    output logic                  int_req_o,
    output logic [1:0]            plv_o
);

    localparam logic [31:0] c_ENTRY_RST = RESET_EENTRY & c_ENTRY_WMASK;

    crmd_t       r_crmd,  w_crmd_nx;
    estat_t      r_estat, w_estat_nx;
    logic [31:0] r_prmd,  w_prmd_nx;
    logic [31:0] r_ecfg,  w_ecfg_nx;
    logic [31:0] r_era,   w_era_nx;
    logic [31:0] r_badv,  w_badv_nx;
    logic [31:0] r_eentry, w_eentry_nx;
    logic [31:0] r_tlbehi, w_tlbehi_nx;
    logic [31:0] r_tlbrentry, w_tlbrentry_nx;
    logic        r_int_req;

    csr_write_signal w_wr [2];
    logic            w_fsm_idle;
    logic            w_take_excp;
    logic            w_take_ertn;
    logic [31:0]     w_target;

    assign w_wr[0]     = cmt.csr_w_i_0;
    assign w_wr[1]     = cmt.csr_w_i_1;
    // The exception beats ERTN; neither is accepted while a redirect is pending.
    assign w_take_excp = cmt.excp_i & w_fsm_idle;
    assign w_take_ertn = cmt.ertn_i & ~cmt.excp_i & w_fsm_idle;

    // Targets use the pre-write CSR values so same-cycle writes cannot retarget.
    assign w_target = w_take_excp ? (cmt.excp_tlbrefill_i ? r_tlbrentry : r_eentry) : r_era;

    // Next CSR state: port 0, then port 1, then exception/ERTN; later steps win.
    always_comb begin
        w_crmd_nx      = r_crmd;
        w_estat_nx     = r_estat;
        w_prmd_nx      = r_prmd;
        w_ecfg_nx      = r_ecfg;
        w_era_nx       = r_era;
        w_badv_nx      = r_badv;
        w_eentry_nx    = r_eentry;
        w_tlbehi_nx    = r_tlbehi;
        w_tlbrentry_nx = r_tlbrentry;
        for (int p = 0; p < 2; p++) begin
            if (w_wr[p].we) begin
                case (w_wr[p].addr)
                    c_ADDR_CRMD:      w_crmd_nx      = crmd_t'(csr_merge(w_crmd_nx, w_wr[p].data, c_CRMD_WMASK));
                    c_ADDR_PRMD:      w_prmd_nx      = csr_merge(w_prmd_nx, w_wr[p].data, c_PRMD_WMASK);
                    c_ADDR_ECFG:      w_ecfg_nx      = csr_merge(w_ecfg_nx, w_wr[p].data, c_ECFG_WMASK);
                    c_ADDR_ESTAT:     w_estat_nx     = estat_t'(csr_merge(w_estat_nx, w_wr[p].data, c_ESTAT_WMASK));
                    c_ADDR_ERA:       w_era_nx       = w_wr[p].data;
                    c_ADDR_BADV:      w_badv_nx      = w_wr[p].data;
                    c_ADDR_EENTRY:    w_eentry_nx    = csr_merge(w_eentry_nx, w_wr[p].data, c_ENTRY_WMASK);
                    c_ADDR_TLBEHI:    w_tlbehi_nx    = csr_merge(w_tlbehi_nx, w_wr[p].data, c_TLBEHI_WMASK);
                    c_ADDR_TLBRENTRY: w_tlbrentry_nx = csr_merge(w_tlbrentry_nx, w_wr[p].data, c_ENTRY_WMASK);
                    default: ;
                endcase
            end
        end
        // Hardware interrupt lines are sampled into IS every cycle.
        w_estat_nx.is[12:2] = 11'(hw_int_i);
        if (w_take_excp) begin
            w_prmd_nx[2]        = r_crmd.ie;
            w_prmd_nx[1:0]      = r_crmd.plv;
            w_crmd_nx.ie        = 1'b0;
            w_crmd_nx.plv       = 2'd0;
            w_estat_nx.ecode    = cmt.csr_ecode_i;
            w_estat_nx.esubcode = cmt.csr_esubcode_i;
            w_era_nx            = cmt.csr_era_i;
            if (cmt.va_error_i) w_badv_nx = cmt.bad_va_i;
            if (cmt.excp_tlb_i) w_tlbehi_nx[31:13] = cmt.excp_tlb_vppn_i;
            if (cmt.excp_tlbrefill_i) begin
                w_crmd_nx.da = 1'b1;
                w_crmd_nx.pg = 1'b0;
            end
        end else if (w_take_ertn) begin
            w_crmd_nx.plv = r_prmd[1:0];
            w_crmd_nx.ie  = r_prmd[2];
            if (r_estat.ecode == c_ECODE_TLBR) begin
                w_crmd_nx.da = 1'b0;
                w_crmd_nx.pg = 1'b1;
            end
        end
    end

    // CSR registers and the interrupt request, which tracks the updated CSRs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crmd      <= crmd_t'(32'h8);
            r_estat     <= estat_t'(32'h0);
            r_prmd      <= 32'h0;
            r_ecfg      <= 32'h0;
            r_era       <= 32'h0;
            r_badv      <= 32'h0;
            r_eentry    <= c_ENTRY_RST;
            r_tlbehi    <= 32'h0;
            r_tlbrentry <= c_ENTRY_RST;
            r_int_req   <= 1'b0;
        end else begin
            r_crmd      <= w_crmd_nx;
            r_estat     <= w_estat_nx;
            r_prmd      <= w_prmd_nx;
            r_ecfg      <= w_ecfg_nx;
            r_era       <= w_era_nx;
            r_badv      <= w_badv_nx;
            r_eentry    <= w_eentry_nx;
            r_tlbehi    <= w_tlbehi_nx;
            r_tlbrentry <= w_tlbrentry_nx;
            r_int_req   <= w_crmd_nx.ie & (|(w_estat_nx.is & w_ecfg_nx[12:0]));
        end
    end

    // Combinational CSR read port; unmapped addresses read as zero.
    always_comb begin
        csr_rdata_o = 32'h0;
        case (csr_raddr_i)
            c_ADDR_CRMD:      csr_rdata_o = r_crmd;
            c_ADDR_PRMD:      csr_rdata_o = r_prmd;
            c_ADDR_ECFG:      csr_rdata_o = r_ecfg;
            c_ADDR_ESTAT:     csr_rdata_o = r_estat;
            c_ADDR_ERA:       csr_rdata_o = r_era;
            c_ADDR_BADV:      csr_rdata_o = r_badv;
            c_ADDR_EENTRY:    csr_rdata_o = r_eentry;
            c_ADDR_TLBEHI:    csr_rdata_o = r_tlbehi;
            c_ADDR_TLBRENTRY: csr_rdata_o = r_tlbrentry;
            default:          csr_rdata_o = 32'h0;
        endcase
    end

    csr_redirect_fsm u_redirect_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_take_excp | w_take_ertn),
        .i_target (w_target),
        .i_ready  (redirect_ready_i),
        .o_valid  (redirect_valid_o),
        .o_pc     (redirect_pc_o),
        .o_idle   (w_fsm_idle)
    );

    assign int_req_o = r_int_req;
    assign plv_o     = r_crmd.plv;

endmodule
`default_nettype wire

// File: tb/tb_csr_excp_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_excp_unit
// Description : Directed self-checking bench for csr_excp_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_excp_unit;
    import csr_excp_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  hw_int_i;
    logic [13:0] csr_raddr_i;
    logic [31:0] csr_rdata_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        int_req_o;
    logic [1:0]  plv_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] v;

    csr_excp_unit_if cif ();

    csr_excp_unit #(.RESET_EENTRY(32'h1c00_0000), .HWI_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmt              (cif),
        .hw_int_i         (hw_int_i),
        .csr_raddr_i      (csr_raddr_i),
        .csr_rdata_o      (csr_rdata_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .int_req_o        (int_req_o),
        .plv_o            (plv_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] d);
        csr_raddr_i = a;
        #1;
        d = csr_rdata_o;
    endtask

    task automatic clr_in();
        cif.csr_w_i_0        = '0;
        cif.csr_w_i_1        = '0;
        cif.excp_i           = 1'b0;
        cif.ertn_i           = 1'b0;
        cif.csr_era_i        = '0;
        cif.csr_ecode_i      = '0;
        cif.csr_esubcode_i   = '0;
        cif.va_error_i       = 1'b0;
        cif.bad_va_i         = '0;
        cif.excp_tlbrefill_i = 1'b0;
        cif.excp_tlb_i       = 1'b0;
        cif.excp_tlb_vppn_i  = '0;
    endtask

    task automatic accept();
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        chk("accept_valid", 32'(redirect_valid_o), 32'h0);
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        hw_int_i = '0;
        csr_raddr_i = '0;
        redirect_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Reset state
        rd(c_ADDR_CRMD, v);      chk("rst_crmd", v, 32'h8);
        rd(c_ADDR_EENTRY, v);    chk("rst_eentry", v, 32'h1c00_0000);
        rd(c_ADDR_TLBRENTRY, v); chk("rst_tlbrentry", v, 32'h1c00_0000);
        chk("rst_valid", 32'(redirect_valid_o), 32'h0);
        chk("rst_pc", redirect_pc_o, 32'h0);
        chk("rst_int", 32'(int_req_o), 32'h0);

        // Set EENTRY and CRMD (PLV=3, IE=1) on both ports in one cycle
        cif.csr_w_i_0 = '{1'b1, c_ADDR_EENTRY, 32'h1c00_8000};
        cif.csr_w_i_1 = '{1'b1, c_ADDR_CRMD, 32'h0000_0007};
        tick();
        clr_in();
        chk("plv3", 32'(plv_o), 32'h3);

        // Exception; same-cycle EENTRY write must not change this target
        cif.excp_i      = 1'b1;
        cif.csr_ecode_i = 6'hB;
        cif.csr_era_i   = 32'h1c00_0100;
        cif.csr_w_i_0   = '{1'b1, c_ADDR_EENTRY, 32'h1c00_4000};
        tick();
        clr_in();
        chk("excp_valid", 32'(redirect_valid_o), 32'h1);
        chk("excp_pc", redirect_pc_o, 32'h1c00_8000);
        rd(c_ADDR_PRMD, v);   chk("excp_prmd", v, 32'h7);
        rd(c_ADDR_CRMD, v);   chk("excp_crmd", v, 32'h0);
        rd(c_ADDR_ERA, v);    chk("excp_era", v, 32'h1c00_0100);
        rd(c_ADDR_ESTAT, v);  chk("excp_estat", v, 32'h000B_0000);
        rd(c_ADDR_EENTRY, v); chk("excp_eentry_wr", v, 32'h1c00_4000);

        // Hold ready low; an exception during REDIR is ignored
        cif.excp_i      = 1'b1;
        cif.csr_ecode_i = 6'h1;
        cif.csr_era_i   = 32'hdead_beef;
        tick();
        clr_in();
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(redirect_valid_o), 32'h1);
            chk("hold_pc", redirect_pc_o, 32'h1c00_8000);
            tick();
        end
        rd(c_ADDR_ERA, v);   chk("redir_era", v, 32'h1c00_0100);
        rd(c_ADDR_ESTAT, v); chk("redir_estat", v, 32'h000B_0000);
        accept();

        // TLB refill exception
        cif.excp_i           = 1'b1;
        cif.csr_ecode_i      = 6'h3F;
        cif.csr_era_i        = 32'h1c00_0200;
        cif.va_error_i       = 1'b1;
        cif.bad_va_i         = 32'h0040_2abc;
        cif.excp_tlb_i       = 1'b1;
        cif.excp_tlb_vppn_i  = 19'h00201;
        cif.excp_tlbrefill_i = 1'b1;
        tick();
        clr_in();
        chk("tlbr_valid", 32'(redirect_valid_o), 32'h1);
        chk("tlbr_pc", redirect_pc_o, 32'h1c00_0000);
        rd(c_ADDR_BADV, v);   chk("tlbr_badv", v, 32'h0040_2abc);
        rd(c_ADDR_TLBEHI, v); chk("tlbr_tlbehi", v, 32'h0040_2000);
        rd(c_ADDR_CRMD, v);   chk("tlbr_crmd", v, 32'h8);
        rd(c_ADDR_ESTAT, v);  chk("tlbr_estat", v, 32'h003F_0000);
        accept();

        // Prepare PRMD (PPLV=2, PIE=1), then ERTN from refill
        cif.csr_w_i_0 = '{1'b1, c_ADDR_PRMD, 32'h0000_0006};
        tick();
        clr_in();
        cif.ertn_i = 1'b1;
        tick();
        clr_in();
        chk("ertn_valid", 32'(redirect_valid_o), 32'h1);
        chk("ertn_pc", redirect_pc_o, 32'h1c00_0200);
        rd(c_ADDR_CRMD, v); chk("ertn_crmd", v, 32'h16);
        chk("ertn_plv", 32'(plv_o), 32'h2);
        accept();

        // Exception and ERTN together: exception only
        cif.excp_i      = 1'b1;
        cif.ertn_i      = 1'b1;
        cif.csr_ecode_i = 6'h2;
        cif.csr_era_i   = 32'h1c00_0300;
        tick();
        clr_in();
        chk("both_pc", redirect_pc_o, 32'h1c00_4000);
        rd(c_ADDR_ERA, v);   chk("both_era", v, 32'h1c00_0300);
        rd(c_ADDR_CRMD, v);  chk("both_crmd", v, 32'h10);
        rd(c_ADDR_PRMD, v);  chk("both_prmd", v, 32'h6);
        rd(c_ADDR_ESTAT, v); chk("both_estat", v, 32'h0002_0000);
        accept();

        // Both ports hit ERA: port 1 wins
        cif.csr_w_i_0 = '{1'b1, c_ADDR_ERA, 32'h11};
        cif.csr_w_i_1 = '{1'b1, c_ADDR_ERA, 32'h22};
        tick();
        clr_in();
        rd(c_ADDR_ERA, v); chk("dual_era", v, 32'h22);
        rd(14'h3, v);      chk("unmapped", v, 32'h0);

        // Interrupts: enable LIE[2] and IE, then raise hw_int[0]
        cif.csr_w_i_0 = '{1'b1, c_ADDR_ECFG, 32'h0000_0004};
        cif.csr_w_i_1 = '{1'b1, c_ADDR_CRMD, 32'h0000_0004};
        tick();
        clr_in();
        chk("int_idle", 32'(int_req_o), 32'h0);
        hw_int_i = 8'h01;
        chk("int_pre", 32'(int_req_o), 32'h0);
        tick();
        chk("int_req", 32'(int_req_o), 32'h1);
        cif.csr_w_i_0 = '{1'b1, c_ADDR_ESTAT, 32'hffff_ffff};
        tick();
        clr_in();
        rd(c_ADDR_ESTAT, v); chk("estat_ro", v, 32'h0002_0007);
        cif.csr_w_i_0 = '{1'b1, c_ADDR_CRMD, 32'h0000_0000};
        tick();
        clr_in();
        chk("int_ie0", 32'(int_req_o), 32'h0);
        hw_int_i = 8'h00;

        // Asynchronous reset while a redirect is pending
        cif.excp_i = 1'b1;
        tick();
        clr_in();
        chk("pre_rst_valid", 32'(redirect_valid_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(redirect_valid_o), 32'h0);
        chk("arst_pc", redirect_pc_o, 32'h0);
        rd(c_ADDR_CRMD, v); chk("arst_crmd", v, 32'h8);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(redirect_valid_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
